// File: rtl/ni_pkg.sv
// Shared types and constants for the network-interface processor port.
// Holds default widths, the TX entry layout and the statistics counter width.
package ni_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 2;
  localparam int CNT_W      = 16;

  typedef struct packed {
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] data;
  } tx_entry_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// First-word-fall-through FIFO used for both the TX and RX queues of ni_proc_port.
// Push while full and pop while empty are ignored; push and pop may coincide.
module ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; clearing the pointers and count already discards its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_proc_port.sv
// Processor-side network interface: TX FIFO toward the router, RX FIFO toward the
// processor, local loopback for self-addressed words. Optional NI_STATS_EN adds counters.
module ni_proc_port
  import ni_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_W   = DEST_W_DEF,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int NODE_ID  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_valid_E,
  input  logic [DEST_W-1:0] dest_add_E,
  input  logic [DATA_W-1:0] NI_in,
  output logic              tx_stall,
  output logic              flit_valid,
  output logic [DEST_W-1:0] flit_dest,
  output logic [DATA_W-1:0] flit_data,
  input  logic              flit_ready,
  input  logic              net_valid,
  input  logic [DATA_W-1:0] net_data,
  output logic              net_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] wd_NI,
  input  logic              proc_ready_in_E,
  output logic [CNT_W-1:0]  tx_sent_cnt,
  output logic [CNT_W-1:0]  rx_recv_cnt
);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } tx_word_t;

  tx_word_t          tx_wdata;
  tx_word_t          tx_head;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] rx_head, rx_wdata;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic              rx_en_q;
  logic              head_local, net_push, loop_push, flit_fire;

  assign tx_wdata = tx_word_t'{dest: dest_add_E, data: NI_in};
  assign tx_push  = proc_valid_E && !tx_full;
  assign tx_stall = tx_full;

  // Receive enable comes up one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_en_q <= 1'b0;
    else      rx_en_q <= 1'b1;
  end

  // Routing decisions: network delivery beats loopback for the single RX write port.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_local = 1'b0;
    flit_valid = 1'b0;
    net_ready  = 1'b0;
    net_push   = 1'b0;
    loop_push  = 1'b0;
    flit_fire  = 1'b0;
    if (!tx_empty) begin
      head_local = (tx_head.dest == DEST_W'(NODE_ID));
      flit_valid = !head_local;
    end
    net_ready = rx_en_q && !rx_full;
    net_push  = net_valid && net_ready;
    loop_push = head_local && !rx_full && !net_push;
    flit_fire = flit_valid && flit_ready;
  end

  assign tx_pop   = flit_fire || loop_push;
  assign rx_push  = net_push || loop_push;
  assign rx_wdata = net_push ? net_data : tx_head.data;

  assign flit_dest  = flit_valid ? tx_head.dest : '0;
  assign flit_data  = flit_valid ? tx_head.data : '0;
  assign data_valid = !rx_empty;
  assign wd_NI      = data_valid ? rx_head : '0;
  assign rx_pop     = proc_ready_in_E && data_valid;

  ni_fifo #(.WIDTH(DEST_W + DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  ni_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (rx_push),
    .wdata (rx_wdata),
    .pop   (rx_pop),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

`ifdef NI_STATS_EN
  logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (flit_fire) tx_cnt_q <= sat_inc(tx_cnt_q);
      if (rx_push)   rx_cnt_q <= sat_inc(rx_cnt_q);
    end
  end

  assign tx_sent_cnt = tx_cnt_q;
  assign rx_recv_cnt = rx_cnt_q;
`else
  assign tx_sent_cnt = '0;
  assign rx_recv_cnt = '0;
`endif

endmodule

// File: tb/tb_ni_proc_port.sv
// Scoreboard bench for ni_proc_port: queue-level reference model predicts handshakes,
// a negedge monitor compares delivered flits and consumed RX words against it.
module tb_ni_proc_port;

  localparam int NODE = 2;

  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        proc_valid_E, flit_ready, net_valid, proc_ready_in_E;
  logic [1:0]  dest_add_E;
  logic [31:0] NI_in, net_data;
  logic        tx_stall, flit_valid, net_ready, data_valid;
  logic [1:0]  flit_dest;
  logic [31:0] flit_data, wd_NI;
  logic [15:0] tx_sent_cnt, rx_recv_cnt;

  always #5 clk = ~clk;

  ni_proc_port #(.DATA_W(32), .DEST_W(2), .TX_DEPTH(4), .RX_DEPTH(4), .NODE_ID(NODE)) dut (
    .clk             (clk),
    .rst             (rst),
    .proc_valid_E    (proc_valid_E),
    .dest_add_E      (dest_add_E),
    .NI_in           (NI_in),
    .tx_stall        (tx_stall),
    .flit_valid      (flit_valid),
    .flit_dest       (flit_dest),
    .flit_data       (flit_data),
    .flit_ready      (flit_ready),
    .net_valid       (net_valid),
    .net_data        (net_data),
    .net_ready       (net_ready),
    .data_valid      (data_valid),
    .wd_NI           (wd_NI),
    .proc_ready_in_E (proc_ready_in_E),
    .tx_sent_cnt     (tx_sent_cnt),
    .rx_recv_cnt     (rx_recv_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t        tx_q[$];
  logic [31:0] rx_q[$];
  bit          m_rx_en;
  int          m_tx_cnt, m_rx_cnt;

  // Scoreboard queues
  ent_t        exp_flit_q[$];
  logic [31:0] exp_rx_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUT actually hands over against the scoreboard.
  always @(negedge clk) begin
    if (flit_valid && flit_ready) begin
      if (exp_flit_q.size() == 0) check("unexpected_flit", {flit_dest, flit_data}, 64'h0);
      else begin
        ent_t e;
        e = exp_flit_q.pop_front();
        check("flit_out", {flit_dest, flit_data}, {e.dest, e.data});
      end
    end
    if (data_valid && proc_ready_in_E) begin
      if (exp_rx_q.size() == 0) check("unexpected_rx", wd_NI, 64'h0);
      else check("rx_out", wd_NI, exp_rx_q.pop_front());
    end
  end

  // One clock cycle: drive inputs just after posedge, predict, check at negedge, update model.
  task automatic cycle(input logic pv, input logic [1:0] d, input logic [31:0] din,
                       input logic fr, input logic nv, input logic [31:0] nd, input logic pr);
    int   tx_n, rx_n;
    bit   e_stall, e_fv, e_nr, e_dv, npush, lb, go, rxpop, txpush;
    ent_t head;
    proc_valid_E = pv; dest_add_E = d; NI_in = din;
    flit_ready = fr; net_valid = nv; net_data = nd; proc_ready_in_E = pr;
    tx_n    = tx_q.size();
    rx_n    = rx_q.size();
    head    = (tx_n > 0) ? tx_q[0] : '0;
    e_stall = (tx_n == 4);
    e_fv    = (tx_n > 0) && (head.dest != 2'(NODE));
    e_nr    = m_rx_en && (rx_n < 4);
    e_dv    = (rx_n > 0);
    npush   = nv && e_nr;
    lb      = (tx_n > 0) && !e_fv && (rx_n < 4) && !npush;
    go      = e_fv && fr;
    rxpop   = pr && e_dv;
    txpush  = pv && !e_stall;
    if (go)    exp_flit_q.push_back(head);
    if (rxpop) exp_rx_q.push_back(rx_q[0]);
    @(negedge clk);
    check("tx_stall", tx_stall, e_stall);
    check("flit_valid", flit_valid, e_fv);
    check("flit_word", {flit_dest, flit_data}, e_fv ? {head.dest, head.data} : 34'h0);
    check("net_ready", net_ready, e_nr);
    check("data_valid", data_valid, e_dv);
    check("wd_NI", wd_NI, e_dv ? rx_q[0] : 32'h0);
`ifdef NI_STATS_EN
    check("tx_sent_cnt", tx_sent_cnt, m_tx_cnt);
    check("rx_recv_cnt", rx_recv_cnt, m_rx_cnt);
`else
    check("tx_sent_cnt", tx_sent_cnt, 0);
    check("rx_recv_cnt", rx_recv_cnt, 0);
`endif
    @(posedge clk);
    if (go || lb) void'(tx_q.pop_front());
    if (rxpop)    void'(rx_q.pop_front());
    if (npush)    rx_q.push_back(nd);
    else if (lb)  rx_q.push_back(head.data);
    if (txpush)   tx_q.push_back('{dest: d, data: din});
    if (go && m_tx_cnt < 16'hFFFF) m_tx_cnt++;
    if ((npush || lb) && m_rx_cnt < 16'hFFFF) m_rx_cnt++;
    m_rx_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n, input logic fr, input logic pr);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'h0, fr, 1'b0, 32'h0, pr);
  endtask

  // Assert reset away from the edge; outputs must drop at once, model and scoreboard empty.
  task automatic do_reset();
    rst = 1'b0;
    proc_valid_E = 1'b0; flit_ready = 1'b0; net_valid = 1'b0; proc_ready_in_E = 1'b0;
    #1;
    check("rst_flit_valid", flit_valid, 1'b0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_net_ready", net_ready, 1'b0);
    check("rst_tx_stall", tx_stall, 1'b0);
    check("rst_tx_cnt", tx_sent_cnt, 16'h0);
    tx_q.delete(); rx_q.delete(); exp_flit_q.delete(); exp_rx_q.delete();
    m_rx_en = 1'b0; m_tx_cnt = 0; m_rx_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_net_ready", net_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("release_net_ready", net_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    proc_valid_E = 1'b0; dest_add_E = '0; NI_in = '0; flit_ready = 1'b0;
    net_valid = 1'b0; net_data = '0; proc_ready_in_E = 1'b0;
    m_rx_en = 1'b0; m_tx_cnt = 0; m_rx_cnt = 0;
    @(posedge clk); #1;
    do_reset();

    // Fill TX toward node 1 with the router stalled; fifth push must be dropped.
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, 32'hC000_0000 + i, 1'b0, 1'b0, 32'h0, 1'b0);
    check("full_stall", tx_stall, 1'b1);
    check("hold_word0", flit_data, 32'hC000_0000);
    idle(4, 1'b1, 1'b0);
    check("drained_stall", tx_stall, 1'b0);
    check("drained_valid", flit_valid, 1'b0);
`ifdef NI_STATS_EN
    check("sent_four", tx_sent_cnt, 16'd4);
`endif

    // Self-addressed word loops back into RX two edges after it is issued.
    cycle(1'b1, 2'(NODE), 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 1'b0);
    check("lb_no_flit", flit_valid, 1'b0);
    check("lb_not_yet", data_valid, 1'b0);
    idle(1, 1'b1, 1'b0);
    check("lb_arrived", data_valid, 1'b1);
    check("lb_word", wd_NI, 32'h0000_00A5);
    idle(1, 1'b0, 1'b1);

    // Network delivery pre-empts a pending loopback; both arrive, network first.
    cycle(1'b1, 2'(NODE), 32'h0000_00A5, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0011, 1'b0);
    idle(1, 1'b0, 1'b0);
    check("prio_head", wd_NI, 32'h0000_0011);
    idle(2, 1'b0, 1'b1);

    // Fill RX from the network, keep offering, then consume concurrently.
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'hB000_0000 + i, 1'b0);
    check("rx_full_ready", net_ready, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'hD000_0000 + i, 1'b1);
    idle(5, 1'b0, 1'b1);

    // Mid-operation reset with three TX and two RX words held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd3, 32'hE000_0000 + i, 1'b0, i < 2, 32'hF000_0000 + i, 1'b0);
    check("pre_rst_valid", flit_valid, 1'b1);
    do_reset();
    idle(2, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 1) == 1);
    idle(12, 1'b1, 1'b1);

    check("scoreboard_flits_left", exp_flit_q.size(), 0);
    check("scoreboard_rx_left", exp_rx_q.size(), 0);
    check("model_tx_left", tx_q.size(), 0);
    check("model_rx_left", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ni_proc_port.md
NI_PROC_PORT -- requirements
Module: ni_proc_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width.
REQ-002 SHALL have parameter DEST_W, default 2, destination node address width.
REQ-003 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries; power of two, >=2.
REQ-004 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries; power of two, >=2.
REQ-005 SHALL have parameter NODE_ID, default 0, own node address (DEST_W bits).
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports, in order:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- proc_valid_E  in  1  processor send request.
- dest_add_E  in  DEST_W  send destination.
- NI_in  in  DATA_W  send payload.
- tx_stall  out  1  TX FIFO full; the pipeline must hold.
- flit_valid  out  1  flit offered to router.
- flit_dest  out  DEST_W  offered destination.
- flit_data  out  DATA_W  offered payload.
- flit_ready  in  1  router accepts flit.
- net_valid  in  1  router delivers flit.
- net_data  in  DATA_W  delivered payload.
- net_ready  out  1  port can accept a delivered flit.
- data_valid  out  1  received word available to the processor.
- wd_NI  out  DATA_W  received word (RX FIFO head).
- proc_ready_in_E  in  1  processor consumes wd_NI.
- tx_sent_cnt  out  16  flits sent to the network.
- rx_recv_cnt  out  16  words written into RX.

Function
REQ-008 SHALL push {dest_add_E, NI_in} into TX FIFO when proc_valid_E=1 and TX count < TX_DEPTH; tx_stall SHALL equal (TX count == TX_DEPTH), combinationally.
REQ-009 SHALL ignore proc_valid_E while full (no push, no overwrite).
REQ-010 SHALL present the TX head first-word-fall-through; a word pushed at edge N is visible on flit_* after edge N (1-cycle latency).
REQ-011 SHALL assert flit_valid iff TX non-empty and head dest != NODE_ID; pop on flit_valid && flit_ready.
REQ-012 SHALL loop a TX head with dest == NODE_ID into RX (local loopback): pop TX, write RX, when RX not full and net_valid&&net_ready is 0 that cycle.
REQ-013 SHALL give network RX writes priority over loopback; loopback waits, nothing dropped.
REQ-014 SHALL accept net_data into RX on net_valid && net_ready; net_ready = rx_en_q && (RX count < RX_DEPTH).
REQ-015 SHALL hold flit_valid, flit_dest and flit_data stable until accepted.
REQ-016 SHALL assert data_valid iff RX non-empty; wd_NI = RX head, else 0; pop on proc_ready_in_E && data_valid; pop when empty is ignored.
REQ-017 SHALL support simultaneous push and pop on either FIFO: count unchanged, both performed.
REQ-018 SHALL use log2(depth)-bit read/write pointers wrapping modulo depth, with a separate count of log2(depth)+1 bits.
REQ-019 SHALL drive flit_dest and flit_data to 0 when flit_valid=0.

Reset
REQ-020 SHALL, on rst=0, asynchronously clear pointers, counts, rx_en_q and counters.
REQ-021 SHALL hold flit_valid=0, data_valid=0, net_ready=0 and tx_stall=0 in reset.
REQ-022 SHALL set rx_en_q at the first clk edge after rst rises; net_ready is therefore first 1 one cycle after release.
REQ-023 SHALL discard all FIFO contents on reset mid-operation; FIFO storage itself is not reset.

Configuration
REQ-024 SHALL, with NI_STATS_EN defined, increment tx_sent_cnt on each flit_valid&&flit_ready and rx_recv_cnt on each RX write (network or loopback), each saturating at 16'hFFFF.
REQ-025 SHALL, without NI_STATS_EN, tie tx_sent_cnt and rx_recv_cnt to 0 and contain no counter flops.

Structure
REQ-026 SHALL place in shared package ni_pkg: DATA_W/DEST_W defaults, the TX entry typedef {dest, data}, and the counter width constant 16.
REQ-027 SHALL implement both FIFOs as one sub-module, ni_fifo (parameters WIDTH, DEPTH), instantiated twice.

Verification
REQ-028 Push 4 words dest=1, flit_ready=0 -> tx_stall=1 after 4th push; 5th push dropped; flit_data holds word 0.
REQ-029 Then flit_ready=1 for 4 cycles -> words 0..3 leave in order; tx_stall=0 after the first pop; tx_sent_cnt=4 with NI_STATS_EN.
REQ-030 NODE_ID=2, push dest=2 data=0xA5 -> flit_valid stays 0; data_valid=1 with wd_NI=0xA5 two cycles after push.
REQ-031 Loopback pending while net_valid=1 with 0x11 -> RX gets 0x11 first, 0xA5 next cycle.
REQ-032 Fill RX with 4 words, keep net_valid=1 -> net_ready=0; assert proc_ready_in_E -> same-cycle push/pop, count stays 4.
REQ-033 Assert rst=0 mid-transfer with TX=3 and RX=2 -> flit_valid=0 and data_valid=0 immediately; net_ready=1 one cycle after release.
